// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-layer blocks.
//   DATA_W     : activation width on the forward-propagation req/ack protocol
//   st_sink_e  : layer_sink FSM state encoding
package nn_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_ARGMAX  = 2'd1,
      ST_PRESENT = 2'd2
   } st_sink_e;

endpackage

// File: rtl/layer_sink.sv
// layer_sink: receiving end of the last neuron layer.
// Collects one activation per lane over per-lane req/ack, then runs a sequential
// signed argmax over the captured frame and offers it to the host on valid/ready.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_ni     asynchronous active-low reset
//   shift_i      synchronous soft clear (scan load in progress)
//   actv_i       lane data, lane i at [DATA_W*i +: DATA_W]
//   req_i        per-lane request, held until acked
//   ack_o        per-lane one-cycle ack pulse
//   data_o       captured frame, packed like actv_i
//   max_o        largest lane value (signed)
//   argmax_o     index of the largest lane (lowest index on ties)
//   valid_o      frame available to host
//   ready_i      host accepts frame
//   busy_o       high while scanning or presenting (upstream stalled)
//   frame_cnt_o  frames accepted by host, wraps
module layer_sink #(
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned DATA_W     = nn_pkg::DATA_W,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         shift_i,
   input  logic [DATA_W*NUM_INPUTS-1:0] actv_i,
   input  logic [NUM_INPUTS-1:0]        req_i,
   output logic [NUM_INPUTS-1:0]        ack_o,
   output logic [DATA_W*NUM_INPUTS-1:0] data_o,
   output logic [DATA_W-1:0]            max_o,
   output logic [IDX_W-1:0]             argmax_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic                         busy_o,
   output logic [CNT_W-1:0]             frame_cnt_o
);

   import nn_pkg::*;

   localparam logic [IDX_W-1:0] LastK = IDX_W'(NUM_INPUTS - 1);

   st_sink_e                     state_q, state_d;
   logic [NUM_INPUTS-1:0]        got_q, got_d;
   logic [NUM_INPUTS-1:0]        ack_q, ack_d;
   logic [DATA_W*NUM_INPUTS-1:0] data_q, data_d;
   logic [DATA_W-1:0]            max_q, max_d;
   logic [IDX_W-1:0]             argmax_q, argmax_d;
   logic [IDX_W-1:0]             k_q, k_d;
   logic                         valid_q, valid_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;

   logic [DATA_W-1:0]            lane_k;

   // Lane under scan comes from the captured bank, not from actv_i.
   assign lane_k = data_q[DATA_W*k_q +: DATA_W];

   always_comb begin
      state_d  = state_q;
      got_d    = got_q;
      ack_d    = '0;
      data_d   = data_q;
      max_d    = max_q;
      argmax_d = argmax_q;
      k_d      = k_q;
      valid_d  = valid_q;
      cnt_d    = cnt_q;

      if (shift_i) begin
         state_d = ST_COLLECT;
         got_d   = '0;
         valid_d = 1'b0;
         k_d     = '0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (&got_q) begin
                  state_d = ST_ARGMAX;
                  k_d     = '0;
               end else begin
                  // got_q masks requests still held after their ack.
                  for (int i = 0; i < NUM_INPUTS; i++) begin
                     if (req_i[i] && !got_q[i]) begin
                        data_d[DATA_W*i +: DATA_W] = actv_i[DATA_W*i +: DATA_W];
                        got_d[i]                   = 1'b1;
                        ack_d[i]                   = 1'b1;
                     end
                  end
               end
            end

            ST_ARGMAX: begin
               if (k_q == '0) begin
                  max_d    = lane_k;
                  argmax_d = '0;
               end else if ($signed(lane_k) > $signed(max_q)) begin
                  // Strict compare keeps the lower index on ties.
                  max_d    = lane_k;
                  argmax_d = k_q;
               end
               if (k_q == LastK) begin
                  state_d = ST_PRESENT;
                  valid_d = 1'b1;
               end else begin
                  k_d = k_q + IDX_W'(1);
               end
            end

            ST_PRESENT: begin
               if (valid_q && ready_i) begin
                  valid_d = 1'b0;
                  got_d   = '0;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = ST_COLLECT;
               end
            end

            default: begin
               state_d = ST_COLLECT;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= ST_COLLECT;
         got_q    <= '0;
         ack_q    <= '0;
         data_q   <= '0;
         max_q    <= '0;
         argmax_q <= '0;
         k_q      <= '0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         got_q    <= got_d;
         ack_q    <= ack_d;
         data_q   <= data_d;
         max_q    <= max_d;
         argmax_q <= argmax_d;
         k_q      <= k_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ack_o       = ack_q;
   assign data_o      = data_q;
   assign max_o       = max_q;
   assign argmax_o    = argmax_q;
   assign valid_o     = valid_q;
   assign busy_o      = (state_q == ST_ARGMAX) || (state_q == ST_PRESENT);
   assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_layer_sink.sv
// Directed bench for layer_sink (NUM_INPUTS=4). A second instance with a
// 2-bit frame counter shares all inputs so counter wrap is reached quickly.
module tb_layer_sink;

   logic         clk_i    = 1'b0;
   logic         reset_ni = 1'b0;
   logic         shift_i  = 1'b0;
   logic         ready_i  = 1'b0;
   logic [127:0] actv_i   = '0;
   logic [3:0]   req_i    = '0;

   logic [3:0]   ack_o;
   logic [127:0] data_o;
   logic [31:0]  max_o;
   logic [1:0]   argmax_o;
   logic         valid_o;
   logic         busy_o;
   logic [15:0]  frame_cnt_o;

   logic [3:0]   ack_s;
   logic [127:0] data_s;
   logic [31:0]  max_s;
   logic [1:0]   argmax_s;
   logic         valid_s;
   logic         busy_s;
   logic [1:0]   cnt_s;

   int total      = 0;
   int bad        = 0;
   int exp_frames = 0;

   layer_sink #(.NUM_INPUTS(4), .DATA_W(32), .CNT_W(16)) u_dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .shift_i(shift_i), .actv_i(actv_i),
      .req_i(req_i), .ack_o(ack_o), .data_o(data_o), .max_o(max_o),
      .argmax_o(argmax_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
      .frame_cnt_o(frame_cnt_o)
   );

   layer_sink #(.NUM_INPUTS(4), .DATA_W(32), .CNT_W(2)) u_dut_small (
      .clk_i(clk_i), .reset_ni(reset_ni), .shift_i(shift_i), .actv_i(actv_i),
      .req_i(req_i), .ack_o(ack_s), .data_o(data_s), .max_o(max_s),
      .argmax_o(argmax_s), .valid_o(valid_s), .ready_i(ready_i), .busy_o(busy_s),
      .frame_cnt_o(cnt_s)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!valid_o && cyc < 50) begin
         step();
         cyc++;
      end
      if (!valid_o) chk("valid_timeout", {127'b0, valid_o}, 128'd1);
   endtask

   task automatic do_hs();
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      exp_frames++;
      chk("hs_valid", {127'b0, valid_o}, 128'd0);
      chk("hs_busy", {127'b0, busy_o}, 128'd0);
      chk("hs_cnt", {112'b0, frame_cnt_o}, 128'(exp_frames % 65536));
      chk("hs_cnt_small", {126'b0, cnt_s}, 128'(exp_frames % 4));
   endtask

   // Full frame with all four reqs in one cycle; checks ack pulse, latency,
   // argmax result and captured data, optionally completes the handshake.
   task automatic run_frame(input logic [31:0] l0, input logic [31:0] l1,
                            input logic [31:0] l2, input logic [31:0] l3,
                            input logic [31:0] emax, input logic [1:0] earg,
                            input bit hs);
      int cyc;
      actv_i = {l3, l2, l1, l0};
      req_i  = 4'hF;
      step();
      chk("ack_all", {124'b0, ack_o}, 128'hF);
      req_i = 4'h0;
      step();
      chk("ack_pulse", {124'b0, ack_o}, 128'h0);
      wait_valid(cyc);
      // valid five edges after the ack edge; one already consumed above
      chk("latency", 128'(cyc), 128'd4);
      chk("max", {96'b0, max_o}, {96'b0, emax});
      chk("argmax", {126'b0, argmax_o}, {126'b0, earg});
      chk("data", data_o, {l3, l2, l1, l0});
      chk("busy_present", {127'b0, busy_o}, 128'd1);
      if (hs) do_hs();
   endtask

   initial begin
      int cyc;
      int arr[4];
      int ack_cnt[4];
      logic [3:0] r;
      logic [3:0] ea;

      // ---- reset state
      step();
      chk("rst_ack", {124'b0, ack_o}, 128'd0);
      chk("rst_valid", {127'b0, valid_o}, 128'd0);
      chk("rst_busy", {127'b0, busy_o}, 128'd0);
      chk("rst_data", data_o, 128'd0);
      chk("rst_max", {96'b0, max_o}, 128'd0);
      chk("rst_argmax", {126'b0, argmax_o}, 128'd0);
      chk("rst_cnt", {112'b0, frame_cnt_o}, 128'd0);
      reset_ni = 1'b1;
      step();

      // ---- all lanes at once, tie at 9 keeps index 2
      run_frame(32'd5, -32'sd3, 32'd9, 32'd9, 32'd9, 2'd2, 1'b1);

      // ---- staggered arrival 2,0,3,1; each req held two cycles past its ack
      arr     = '{1, 3, 0, 2};
      ack_cnt = '{0, 0, 0, 0};
      actv_i  = {32'd50, 32'd7, 32'hFFFF_FFFF, 32'd100};
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < 4; i++) begin
            r[i]  = (s >= arr[i]) && (s <= arr[i] + 2);
            ea[i] = (s == arr[i]);
         end
         req_i = r;
         step();
         chk("stag_ack", {124'b0, ack_o}, {124'b0, ea});
         for (int i = 0; i < 4; i++) ack_cnt[i] += int'(ack_o[i]);
         if (s == 2) chk("stag_busy_lo", {127'b0, busy_o}, 128'd0);
         if (s == 4) chk("stag_busy_hi", {127'b0, busy_o}, 128'd1);
      end
      req_i = 4'h0;
      for (int i = 0; i < 4; i++) chk("stag_ack_once", 128'(ack_cnt[i]), 128'd1);
      wait_valid(cyc);
      chk("stag_latency", 128'(cyc), 128'd3);
      chk("stag_max", {96'b0, max_o}, 128'd100);
      chk("stag_argmax", {126'b0, argmax_o}, 128'd0);
      chk("stag_data", data_o, {32'd50, 32'd7, 32'hFFFF_FFFF, 32'd100});
      do_hs();

      // ---- all negative: signed compare picks -2 at lane 1
      run_frame(-32'sd8, -32'sd2, -32'sd7, -32'sd100, 32'hFFFF_FFFE, 2'd1, 1'b0);

      // ---- host stalls 10 cycles while new reqs wait upstream
      actv_i = {32'd4, 32'd3, 32'd2, 32'd1};
      req_i  = 4'hF;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("stall_ack", {124'b0, ack_o}, 128'd0);
         chk("stall_valid", {127'b0, valid_o}, 128'd1);
         chk("stall_busy", {127'b0, busy_o}, 128'd1);
         chk("stall_max", {96'b0, max_o}, 128'hFFFF_FFFE);
         chk("stall_data", data_o, {-32'sd100, -32'sd7, -32'sd2, -32'sd8});
      end
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      exp_frames++;
      chk("stall_cnt", {112'b0, frame_cnt_o}, 128'(exp_frames));
      chk("stall_vld_lo", {127'b0, valid_o}, 128'd0);
      step();
      chk("stall_newack", {124'b0, ack_o}, 128'hF);
      req_i = 4'h0;
      step();
      wait_valid(cyc);
      chk("stall_max2", {96'b0, max_o}, 128'd4);
      chk("stall_arg2", {126'b0, argmax_o}, 128'd3);
      do_hs();
      chk("cnt_wrap_small_a", {126'b0, cnt_s}, 128'd0);

      // ---- soft clear after two lanes captured
      actv_i = {-32'sd5, 32'd30, 32'd20, 32'd10};
      req_i  = 4'b0011;
      step();
      chk("shift_pre_ack", {124'b0, ack_o}, 128'h3);
      req_i = 4'h0;
      step();
      shift_i = 1'b1;
      step();
      shift_i = 1'b0;
      chk("shift_ack", {124'b0, ack_o}, 128'd0);
      chk("shift_valid", {127'b0, valid_o}, 128'd0);
      chk("shift_busy", {127'b0, busy_o}, 128'd0);
      chk("shift_cnt", {112'b0, frame_cnt_o}, 128'(exp_frames));
      chk("shift_lane0", {96'b0, data_o[31:0]}, 128'd10);
      run_frame(32'd10, 32'd20, 32'd30, -32'sd5, 32'd30, 2'd2, 1'b1);

      // ---- asynchronous reset in the middle of the argmax scan
      actv_i = {32'd1, 32'd1, 32'd1, 32'd1};
      req_i  = 4'hF;
      step();
      req_i = 4'h0;
      step();
      step();
      chk("pre_rst_busy", {127'b0, busy_o}, 128'd1);
      #2;
      reset_ni = 1'b0;
      #1;
      exp_frames = 0;
      chk("arst_ack", {124'b0, ack_o}, 128'd0);
      chk("arst_valid", {127'b0, valid_o}, 128'd0);
      chk("arst_busy", {127'b0, busy_o}, 128'd0);
      chk("arst_data", data_o, 128'd0);
      chk("arst_max", {96'b0, max_o}, 128'd0);
      chk("arst_argmax", {126'b0, argmax_o}, 128'd0);
      chk("arst_cnt", {112'b0, frame_cnt_o}, 128'd0);
      @(negedge clk_i);
      reset_ni = 1'b1;
      step();

      // ---- four frames: small counter wraps 3 -> 0
      for (int f = 0; f < 4; f++) begin
         run_frame(32'd0, 32'd7, -32'sd1, 32'd7, 32'd7, 2'd1, 1'b1);
      end
      chk("cnt_wrap_small_b", {126'b0, cnt_s}, 128'd0);
      chk("cnt_main_4", {112'b0, frame_cnt_o}, 128'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
